// File: rtl/csp_split11_pkg.sv
// Shared types and widths for the CSP split demultiplexer.
package csp_pkg;

    localparam int CSP_FLIT_W = 11;
    localparam int CSP_CNT_W  = 16;

    typedef enum logic [2:0] {
        C_WAIT = 3'd0,
        C_RTZ  = 3'd1,
        X_WAIT = 3'd2,
        X_RTZ  = 3'd3,
        Z_WAIT = 3'd4,
        Z_RTZ  = 3'd5
    } state_t;

endpackage

// File: rtl/csp_split11_hs_rx.sv
// Four-phase receive slot: captures data and raises ack one edge after req while armed, drops ack one edge after req falls.
// Latency 1 cycle per phase; backpressure: req is simply not acknowledged until the owner arms the slot.
module csp_hs_rx #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_arm,
    input  logic         i_req,
    input  logic [W-1:0] i_data,
    output logic         o_ack,
    output logic [W-1:0] o_data,
    output logic         o_take,
    output logic         o_done
);

    logic         r_ack;
    logic [W-1:0] r_data;

    // take and done are mutually exclusive: ack low vs. ack high
    assign o_take = i_arm && !r_ack && i_req;
    assign o_done = r_ack && !i_req;
    assign o_ack  = r_ack;
    assign o_data = r_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ack  <= 1'b0;
            r_data <= '0;
        end else if (o_take) begin
            r_ack  <= 1'b1;
            r_data <= i_data;
        end else if (o_done) begin
            r_ack  <= 1'b0;
        end
    end

endmodule

// File: rtl/csp_split11.sv
// Steers one X token to Z0 or Z1 by a preceding C select token; z req rises 3 edges after c_req is first sampled, 6-cycle period.
// Backpressure: holds z req and data until the selected ack; no new C/X accepted meanwhile. Macro CSP_SPLIT_COUNT_EN adds cnt0/cnt1.
module csp_split11
    import csp_pkg::*;
#(
    parameter int WIDTH = CSP_FLIT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_req,
    input  logic             c_data,
    output logic             c_ack,
    input  logic             x_req,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ack,
    output logic             z0_req,
    output logic [WIDTH-1:0] z0_data,
    input  logic             z0_ack,
    output logic             z1_req,
    output logic [WIDTH-1:0] z1_data,
    input  logic             z1_ack
`ifdef CSP_SPLIT_COUNT_EN
    ,
    output logic [CSP_CNT_W-1:0] cnt0,
    output logic [CSP_CNT_W-1:0] cnt1
`endif
);

    state_t           r_state;
    logic             r_z0_req;
    logic             r_z1_req;
    logic [WIDTH-1:0] r_z0_data;
    logic [WIDTH-1:0] r_z1_data;

    logic             w_c_take;
    logic             w_c_done;
    logic             w_sel;
    logic             w_x_take;
    logic             w_x_done;
    logic [WIDTH-1:0] w_xbuf;
    logic             w_z_ack;

    csp_hs_rx #(.W(1)) u_c_slot (
        .clk    (clk),
        .reset  (reset),
        .i_arm  (r_state == C_WAIT),
        .i_req  (c_req),
        .i_data (c_data),
        .o_ack  (c_ack),
        .o_data (w_sel),
        .o_take (w_c_take),
        .o_done (w_c_done)
    );

    csp_hs_rx #(.W(WIDTH)) u_x_slot (
        .clk    (clk),
        .reset  (reset),
        .i_arm  (r_state == X_WAIT),
        .i_req  (x_req),
        .i_data (x_data),
        .o_ack  (x_ack),
        .o_data (w_xbuf),
        .o_take (w_x_take),
        .o_done (w_x_done)
    );

    // Only the selected port's ack participates; the other is ignored.
    assign w_z_ack = w_sel ? z1_ack : z0_ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= C_WAIT;
            r_z0_req  <= 1'b0;
            r_z1_req  <= 1'b0;
            r_z0_data <= '0;
            r_z1_data <= '0;
        end else begin
            case (r_state)
                C_WAIT: if (w_c_take) r_state <= C_RTZ;
                C_RTZ:  if (w_c_done) r_state <= X_WAIT;
                X_WAIT: if (w_x_take) r_state <= X_RTZ;
                X_RTZ: begin
                    if (w_x_done) begin
                        if (w_sel) begin
                            r_z1_data <= w_xbuf;
                            r_z1_req  <= 1'b1;
                        end else begin
                            r_z0_data <= w_xbuf;
                            r_z0_req  <= 1'b1;
                        end
                        r_state <= Z_WAIT;
                    end
                end
                Z_WAIT: begin
                    if (w_z_ack) begin
                        r_z0_req <= 1'b0;
                        r_z1_req <= 1'b0;
                        r_state  <= Z_RTZ;
                    end
                end
                Z_RTZ:  if (!w_z_ack) r_state <= C_WAIT;
                default: r_state <= C_WAIT;
            endcase
        end
    end

    assign z0_req  = r_z0_req;
    assign z1_req  = r_z1_req;
    assign z0_data = r_z0_data;
    assign z1_data = r_z1_data;

`ifdef CSP_SPLIT_COUNT_EN
    logic [CSP_CNT_W-1:0] r_cnt0;
    logic [CSP_CNT_W-1:0] r_cnt1;

    // Counts completed deliveries per port; wraps naturally at the width.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (r_state == Z_WAIT && w_z_ack) begin
            if (w_sel) r_cnt1 <= r_cnt1 + 1'b1;
            else       r_cnt0 <= r_cnt0 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_csp_split11.sv
// Directed bench for csp_split11: reset, both output ports, stalls, spurious acks, early x_req, reset in Z_WAIT.
module tb_csp_split11;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         reset;
    logic         c_req, c_data, c_ack;
    logic         x_req, x_ack;
    logic [W-1:0] x_data;
    logic         z0_req, z0_ack, z1_req, z1_ack;
    logic [W-1:0] z0_data, z1_data;
`ifdef CSP_SPLIT_COUNT_EN
    logic [15:0]  cnt0, cnt1;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    csp_split11 dut (
        .clk     (clk),
        .reset   (reset),
        .c_req   (c_req),
        .c_data  (c_data),
        .c_ack   (c_ack),
        .x_req   (x_req),
        .x_data  (x_data),
        .x_ack   (x_ack),
        .z0_req  (z0_req),
        .z0_data (z0_data),
        .z0_ack  (z0_ack),
        .z1_req  (z1_req),
        .z1_data (z1_data),
        .z1_ack  (z1_ack)
`ifdef CSP_SPLIT_COUNT_EN
        ,
        .cnt0    (cnt0),
        .cnt1    (cnt1)
`endif
    );

    // Advance one rising edge; observe and drive on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b0;
        c_req  = 1'b1;
        c_data = 1'b0;
        x_req  = 1'b1;
        x_data = 11'h5A3;
        z0_ack = 1'b0;
        z1_ack = 1'b0;

        // Reset held with requests pending
        step();
        step();
        chk("rst_c_ack", c_ack, 0);
        chk("rst_x_ack", x_ack, 0);
        chk("rst_z0_req", z0_req, 0);
        chk("rst_z1_req", z1_req, 0);
        chk("rst_z0_data", z0_data, 0);
        chk("rst_z1_data", z1_data, 0);

        // C=0, X=0x5A3, zero-delay environment; E0 is the first sampling edge
        reset = 1'b1;
        step();                                   // E0
        chk("t2_c_ack_e0", c_ack, 1);
        chk("t2_x_ack_early", x_ack, 0);
        c_req = 1'b0;
        step();                                   // E1
        chk("t2_c_ack_e1", c_ack, 0);
        chk("t2_x_ack_e1", x_ack, 0);
        step();                                   // E2
        chk("t2_x_ack_e2", x_ack, 1);
        chk("t2_z0_req_e2", z0_req, 0);
        x_req = 1'b0;
        step();                                   // E3: fourth edge counting E0
        chk("t2_z0_req_e3", z0_req, 1);
        chk("t2_z0_data", z0_data, 11'h5A3);
        chk("t2_z1_req", z1_req, 0);
        chk("t2_x_ack_e3", x_ack, 0);
        z0_ack = 1'b1;
        c_req  = 1'b1;                            // early C, must wait for C_WAIT
        c_data = 1'b1;
        step();                                   // E4
        chk("t2_z0_req_e4", z0_req, 0);
        chk("t2_c_ack_e4", c_ack, 0);
        z0_ack = 1'b0;
        step();                                   // E5
        chk("t2_c_ack_e5", c_ack, 0);
        step();                                   // E6
        chk("t2_c_ack_e6", c_ack, 1);

        // C=1, X=0x7FF, z1_ack stalled 10 cycles with spurious z0_ack
        c_req  = 1'b0;
        x_data = 11'h7FF;
        x_req  = 1'b1;
        step();
        chk("t3_c_ack_rtz", c_ack, 0);
        step();
        chk("t3_x_ack", x_ack, 1);
        x_req = 1'b0;
        step();
        chk("t3_z1_req", z1_req, 1);
        chk("t3_z1_data", z1_data, 11'h7FF);
        chk("t3_z0_req", z0_req, 0);
        chk("t3_z0_data_held", z0_data, 11'h5A3);
        for (int i = 0; i < 10; i++) begin
            z0_ack = i[0];
            step();
            chk("t3_stall_z1_req", z1_req, 1);
            chk("t3_stall_z1_data", z1_data, 11'h7FF);
            chk("t3_stall_x_ack", x_ack, 0);
            chk("t3_stall_c_ack", c_ack, 0);
            chk("t3_stall_z0_req", z0_req, 0);
        end
        z0_ack = 1'b1;
        step();
        chk("t4_spurious_z1_req", z1_req, 1);
        z0_ack = 1'b0;
        z1_ack = 1'b1;
        step();
        chk("t4_z1_req_drop", z1_req, 0);
        chk("t4_z1_data_hold", z1_data, 11'h7FF);
        z1_ack = 1'b0;
        step();                                   // back in C_WAIT

        // x_req raised before c_req
        x_data = 11'h123;
        x_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_x_ack_blocked", x_ack, 0);
        end
        c_req  = 1'b1;
        c_data = 1'b0;
        step();
        chk("t5_c_ack", c_ack, 1);
        chk("t5_x_ack_c_phase", x_ack, 0);
        c_req = 1'b0;
        step();
        chk("t5_x_ack_c_rtz", x_ack, 0);
        step();
        chk("t5_x_ack_served", x_ack, 1);
        x_req = 1'b0;
        step();
        chk("t5_z0_req", z0_req, 1);
        chk("t5_z0_data", z0_data, 11'h123);
        chk("t5_z1_req", z1_req, 0);

        // Reset while in Z_WAIT
        reset = 1'b0;
        step();
        chk("t6_z0_req", z0_req, 0);
        chk("t6_z0_data", z0_data, 0);
        chk("t6_z1_data", z1_data, 0);
        reset  = 1'b1;
        c_req  = 1'b1;
        c_data = 1'b1;
        step();
        chk("t6_c_wait_c_ack", c_ack, 1);
        chk("t6_x_ack", x_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
